// File: rtl/count_seq_monitor.sv
// Sequence checker for the 3-bit binary/Gray counter: predicts each count from the
// previous sample, locks after LOCK_LEN good steps, flags violations and wraps.
module count_seq_monitor #(
   parameter int LOCK_LEN = 4,
   parameter int STAT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic              cnt_reset,
   input  logic [2:0]        count,
   input  logic              clear,
   output logic [2:0]        value,
   output logic              locked,
   output logic              err,
   output logic              wrap,
   output logic [STAT_W-1:0] err_cnt,
   output logic [STAT_W-1:0] wrap_cnt,
   output logic              dbg_state,
   output logic [3:0]        dbg_run
);

   localparam logic [3:0] LOCK_LEN_L = 4'(LOCK_LEN);

   typedef enum logic {ACQ = 1'b0, LOCKED = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [3:0] run, run_nxt;

   logic [2:0] p_count;
   logic       p_mode;
   logic       p_rst;
   logic       have_prev;

   logic [2:0] expected;
   logic [2:0] cur_bin;
   logic [2:0] prev_bin;
   logic       match;
   logic       mismatch;
   logic       wrap_hit;
   logic       err_nxt;
   logic       wrap_nxt;

   function automatic logic [2:0] gray2bin(input logic [2:0] g);
      return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
   endfunction

   function automatic logic [2:0] bin2gray(input logic [2:0] b);
      return b ^ {1'b0, b[2:1]};
   endfunction

   // Prediction uses the mode sampled alongside the previous count, as the counter does.
   always_comb begin
      expected = 3'd0;
      if (p_rst)
         expected = 3'd0;
      else if (!p_mode)
         expected = p_count + 3'd1;
      else
         expected = bin2gray(gray2bin(p_count) + 3'd1);
   end

   always_comb begin
      cur_bin  = mode ? gray2bin(count) : count;
      prev_bin = p_mode ? gray2bin(p_count) : p_count;
      match    = have_prev && (count == expected);
      mismatch = have_prev && (count != expected);
      wrap_hit = match && !p_rst && (prev_bin == 3'd7) && (cur_bin == 3'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ACQ;
         run   <= 4'd0;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      case (state)
         ACQ: begin
            if (match) begin
               if (run + 4'd1 == LOCK_LEN_L) begin
                  state_nxt = LOCKED;
                  run_nxt   = 4'd0;
               end else begin
                  run_nxt = run + 4'd1;
               end
            end else if (mismatch) begin
               run_nxt = 4'd0;
            end
         end
         LOCKED: begin
            if (mismatch) begin
               state_nxt = ACQ;
               run_nxt   = 4'd0;
            end
         end
         default: begin
            state_nxt = ACQ;
            run_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      err_nxt  = (state == LOCKED) && mismatch;
      wrap_nxt = wrap_hit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value     <= 3'd0;
         locked    <= 1'b0;
         err       <= 1'b0;
         wrap      <= 1'b0;
         p_count   <= 3'd0;
         p_mode    <= 1'b0;
         p_rst     <= 1'b0;
         have_prev <= 1'b0;
      end else begin
         value     <= cur_bin;
         locked    <= (state_nxt == LOCKED);
         err       <= err_nxt;
         wrap      <= wrap_nxt;
         p_count   <= count;
         p_mode    <= mode;
         p_rst     <= cnt_reset;
         have_prev <= 1'b1;
      end
   end

   // Saturating statistics; clear takes priority over a same-edge increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_cnt  <= '0;
         wrap_cnt <= '0;
      end else if (clear) begin
         err_cnt  <= '0;
         wrap_cnt <= '0;
      end else begin
         if (err_nxt && !(&err_cnt))
            err_cnt <= err_cnt + STAT_W'(1);
         if (wrap_nxt && !(&wrap_cnt))
            wrap_cnt <= wrap_cnt + STAT_W'(1);
      end
   end

   assign dbg_state = state;
   assign dbg_run   = run;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Randomised and directed bench for count_seq_monitor against a table-driven model;
// a second instance with STAT_W = 2 covers counter saturation.
module tb_count_seq_monitor;

   localparam int LOCK_LEN = 4;
   localparam logic [2:0] GRAY [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       mode = 1'b0;
   logic       cnt_reset = 1'b0;
   logic [2:0] count = 3'd0;
   logic       clear = 1'b0;

   logic [2:0] value;
   logic       locked, err, wrap, dbg_state;
   logic [7:0] err_cnt, wrap_cnt;
   logic [3:0] dbg_run;

   logic [2:0] s_value;
   logic       s_locked, s_err, s_wrap, s_dbg_state;
   logic [1:0] s_err_cnt, s_wrap_cnt;
   logic [3:0] s_dbg_run;

   int total = 0;
   int bad = 0;

   // model state
   logic [2:0] m_p_count, m_value;
   bit         m_p_mode, m_p_rst, m_have_prev, m_locked, m_err, m_wrap;
   int         m_run, m_err_cnt, m_wrap_cnt, m_serr, m_swrap;

   always #5 clk = ~clk;

   count_seq_monitor #(.LOCK_LEN(LOCK_LEN), .STAT_W(8)) dut (
      .clk(clk), .reset(reset), .mode(mode), .cnt_reset(cnt_reset), .count(count),
      .clear(clear), .value(value), .locked(locked), .err(err), .wrap(wrap),
      .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .dbg_state(dbg_state), .dbg_run(dbg_run)
   );

   count_seq_monitor #(.LOCK_LEN(LOCK_LEN), .STAT_W(2)) dut_s (
      .clk(clk), .reset(reset), .mode(mode), .cnt_reset(cnt_reset), .count(count),
      .clear(clear), .value(s_value), .locked(s_locked), .err(s_err), .wrap(s_wrap),
      .err_cnt(s_err_cnt), .wrap_cnt(s_wrap_cnt), .dbg_state(s_dbg_state), .dbg_run(s_dbg_run)
   );

   wire [30:0] obs = {value, locked, err, wrap, err_cnt, wrap_cnt,
                      s_err_cnt, s_wrap_cnt, dbg_state, dbg_run};

   function automatic int gpos(input logic [2:0] c);
      int p = 0;
      for (int i = 0; i < 8; i++)
         if (GRAY[i] == c) p = i;
      return p;
   endfunction

   function automatic logic [2:0] succ(input logic [2:0] c, input bit m, input bit r);
      if (r) return 3'd0;
      if (m) return GRAY[(gpos(c) + 1) % 8];
      return 3'((int'(c) + 1) % 8);
   endfunction

   function automatic logic [30:0] exp_vec();
      return {m_value, m_locked, m_err, m_wrap, 8'(m_err_cnt), 8'(m_wrap_cnt),
              2'(m_serr), 2'(m_swrap), m_locked, 4'(m_run)};
   endfunction

   task automatic model_reset();
      m_p_count = 3'd0; m_p_mode = 1'b0; m_p_rst = 1'b0; m_have_prev = 1'b0;
      m_locked = 1'b0; m_err = 1'b0; m_wrap = 1'b0; m_value = 3'd0; m_run = 0;
      m_err_cnt = 0; m_wrap_cnt = 0; m_serr = 0; m_swrap = 0;
   endtask

   task automatic model_step(input logic [2:0] c, input bit m, input bit r, input bit clr);
      int  dec, pdec;
      bit  match;
      dec = m ? gpos(c) : int'(c);
      m_err = 1'b0;
      m_wrap = 1'b0;
      if (m_have_prev) begin
         match = (c == succ(m_p_count, m_p_mode, m_p_rst));
         pdec  = m_p_mode ? gpos(m_p_count) : int'(m_p_count);
         m_wrap = match && !m_p_rst && pdec == 7 && dec == 0;
         if (m_locked) begin
            if (!match) begin
               m_err = 1'b1; m_locked = 1'b0; m_run = 0;
            end
         end else if (match) begin
            m_run++;
            if (m_run == LOCK_LEN) begin
               m_locked = 1'b1; m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      if (clr) begin
         m_err_cnt = 0; m_wrap_cnt = 0; m_serr = 0; m_swrap = 0;
      end else begin
         if (m_err)  begin m_err_cnt  = (m_err_cnt  < 255) ? m_err_cnt + 1  : 255; m_serr  = (m_serr  < 3) ? m_serr + 1  : 3; end
         if (m_wrap) begin m_wrap_cnt = (m_wrap_cnt < 255) ? m_wrap_cnt + 1 : 255; m_swrap = (m_swrap < 3) ? m_swrap + 1 : 3; end
      end
      m_p_count = c; m_p_mode = m; m_p_rst = r; m_have_prev = 1'b1;
      m_value = 3'(dec);
   endtask

   task automatic step(input logic [2:0] c, input bit m, input bit r, input bit clr);
      @(negedge clk);
      count = c; mode = m; cnt_reset = r; clear = clr;
      @(posedge clk);
      model_step(c, m, r, clr);
      #1;
   endtask

   task automatic good(input bit m, input bit r, input bit clr);
      step(succ(m_p_count, m_p_mode, m_p_rst), m, r, clr);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      if (obs !== 31'h0) begin bad++; $display("FAIL reset got=%h want=0", obs); end
      total++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_binary();
      step(3'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 19; i++) begin
         good(1'b0, 1'b0, 1'b0);
         if (obs !== exp_vec()) begin bad++; $display("FAIL binary cyc=%0d got=%h want=%h", i, obs, exp_vec()); end
         total++;
         if (i == 3) begin
            if (locked !== 1'b1) begin bad++; $display("FAIL binary_lock got=%b want=1", locked); end
            total++;
         end
      end
      if (wrap_cnt !== 8'd2 || err_cnt !== 8'd0) begin
         bad++; $display("FAIL binary_stats wrap_cnt=%0d err_cnt=%0d want 2/0", wrap_cnt, err_cnt);
      end
      total++;
   endtask

   task automatic test_gray();
      good(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) begin
         good(1'b1, 1'b0, 1'b0);
         if (obs !== exp_vec() || value !== 3'(k % 8) || locked !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL gray k=%0d got=%h want=%h value=%0d", k, obs, exp_vec(), value);
         end
         total++;
      end
   endtask

   task automatic test_fault();
      for (int i = 0; i < 16 && !(m_p_count == 3'd3 && !m_p_mode); i++) good(1'b0, 1'b0, 1'b0);
      step(3'd5, 1'b0, 1'b0, 1'b0);
      if (obs !== exp_vec() || err !== 1'b1 || locked !== 1'b0) begin
         bad++; $display("FAIL fault_err got=%h want=%h", obs, exp_vec());
      end
      total++;
      for (int i = 0; i < 4; i++) begin
         good(1'b0, 1'b0, 1'b0);
         if (obs !== exp_vec() || locked !== (i == 3) || err !== 1'b0) begin
            bad++; $display("FAIL fault_relock i=%0d got=%h want=%h", i, obs, exp_vec());
         end
         total++;
      end
      if (err_cnt !== 8'd1) begin bad++; $display("FAIL fault_cnt got=%0d want=1", err_cnt); end
      total++;
   endtask

   task automatic test_mode_switch();
      for (int i = 0; i < 16 && !(m_p_count == 3'd2 && !m_p_mode); i++) good(1'b0, 1'b0, 1'b0);
      good(1'b1, 1'b0, 1'b0);
      good(1'b1, 1'b0, 1'b0);
      if (obs !== exp_vec() || count !== 3'b010 || err !== 1'b0 || locked !== 1'b1) begin
         bad++; $display("FAIL mode_switch count=%b got=%h want=%h", count, obs, exp_vec());
      end
      total++;
   endtask

   task automatic test_cnt_reset();
      for (int i = 0; i < 16 && !(m_p_count == 3'd5 && !m_p_mode); i++) good(1'b0, 1'b0, 1'b0);
      good(1'b0, 1'b1, 1'b0);
      good(1'b0, 1'b0, 1'b0);
      if (obs !== exp_vec() || count !== 3'd0 || wrap !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL cnt_reset got=%h want=%h", obs, exp_vec());
      end
      total++;
      step(succ(m_p_count, m_p_mode, m_p_rst) ^ 3'b100, 1'b0, 1'b0, 1'b1);
      if (obs !== exp_vec() || err !== 1'b1 || err_cnt !== 8'd0) begin
         bad++; $display("FAIL clear_vs_err got=%h want=%h", obs, exp_vec());
      end
      total++;
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 5; n++) begin
         repeat (LOCK_LEN) good(1'b0, 1'b0, 1'b0);
         step(succ(m_p_count, m_p_mode, m_p_rst) ^ 3'b011, 1'b0, 1'b0, 1'b0);
         if (obs !== exp_vec() || err !== 1'b1) begin
            bad++; $display("FAIL sat n=%0d got=%h want=%h", n, obs, exp_vec());
         end
         total++;
      end
      if (s_err_cnt !== 2'd3 || err_cnt !== 8'd5) begin
         bad++; $display("FAIL sat_cnt s_err_cnt=%0d err_cnt=%0d want 3/5", s_err_cnt, err_cnt);
      end
      total++;
   endtask

   task automatic test_random();
      bit m = 1'b0;
      for (int i = 0; i < 400; i++) begin
         bit r, clr;
         logic [2:0] c;
         if ($urandom_range(0, 99) < 10) m = ~m;
         r   = ($urandom_range(0, 99) < 8);
         clr = ($urandom_range(0, 99) < 5);
         c   = succ(m_p_count, m_p_mode, m_p_rst);
         if ($urandom_range(0, 99) < 8) c = c ^ 3'($urandom_range(1, 7));
         step(c, m, r, clr);
         if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec()); end
         total++;
      end
   endtask

   task automatic test_async_reset();
      repeat (6) good(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      if (obs !== 31'h0 || s_value !== 3'd0 || s_locked !== 1'b0 || s_dbg_run !== 4'd0) begin
         bad++; $display("FAIL async_reset got=%h want=0", obs);
      end
      total++;
      @(negedge clk);
      reset = 1'b1;
      step(3'd6, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         good(1'b0, 1'b0, 1'b0);
         if (obs !== exp_vec() || s_err !== 1'b0 || s_wrap !== wrap || s_dbg_state !== locked) begin
            bad++; $display("FAIL after_reset i=%0d got=%h want=%h", i, obs, exp_vec());
         end
         total++;
      end
   endtask

   initial begin
      test_reset();
      test_binary();
      test_gray();
      test_fault();
      test_mode_switch();
      test_cnt_reset();
      test_saturation();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/count_seq_monitor.md
# count_seq_monitor

Downstream checker for the 3-bit binary/Gray JK counter. Each clock it samples the counter's `count`, `mode` and `cnt_reset` inputs, predicts the next value from the previous sample, and flags sequence violations. It also outputs the count decoded to binary and keeps saturating error and wrap statistics. It sits directly on the counter's output bus and feeds status and debug logic.

## Interface
- `LOCK_LEN`, default 4: consecutive correct steps required to enter LOCKED (legal range 1–15).
- `STAT_W`, default 8: width of the `err_cnt` and `wrap_cnt` statistic counters.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mode` input 1: the counter's mode (0 = binary, 1 = Gray), the same signal that drives the counter.
- `cnt_reset` input 1: the counter's synchronous reset, the same signal that drives the counter.
- `count` input 3: counter output.
- `clear` input 1: synchronous clear of `err_cnt` and `wrap_cnt`.
- `value` output 3: `count` decoded to binary, registered.
- `locked` output 1: high while in the LOCKED state.
- `err` output 1: one-cycle pulse on a sequence violation while LOCKED.
- `wrap` output 1: one-cycle pulse on a correct wrap to zero.
- `err_cnt` output STAT_W: saturating count of `err` pulses.
- `wrap_cnt` output STAT_W: saturating count of `wrap` pulses.

## Operation
- **History registers:** `p_count`, `p_mode`, `p_rst` and `have_prev` capture `count`, `mode`, `cnt_reset` and 1 on every edge.
- **Expected value** at edge k is computed from the sample taken at edge k-1:
  - if `p_rst`: 000;
  - else if `p_mode` = 0: `p_count` + 1 mod 8;
  - else: the Gray successor in the sequence 000→001→011→010→110→111→101→100→000.
- **Match:** `have_prev` & (`count` == expected). When `have_prev` = 0 (first edge after reset) the result is neither a match nor a mismatch.
- **Mode changes** need no special handling. The rule uses the mode sampled with the previous count, which matches how the counter applies its mode.
- **Decode:** when `mode` = 0, `value` = `count`. When `mode` = 1, `value` = {g2, g2^g1, g2^g1^g0}, using the current-cycle `mode`.
- **State machine (2 states):**
  - ACQ: `run` counts consecutive matches; a mismatch resets `run` to 0. On the match that brings `run` to LOCK_LEN, go to LOCKED and clear `run`. Mismatches in ACQ do not assert `err`.
  - LOCKED: a match stays in LOCKED. A mismatch asserts `err`, increments `err_cnt`, returns to ACQ and sets `run` to 0.
- **Wrap:** asserted on a match with `p_rst` = 0 where the previous sample decodes to binary 7 and the current sample to 0, in either state. A return to 000 due to `cnt_reset` is not a wrap.
- **Statistics:** both counters saturate at 2^STAT_W−1. If `clear` and an increment occur on the same edge, `clear` wins and the result is 0. `clear` does not affect the state machine, `run` or history.

## Timing
- **Reset values** (while `reset` = 0, asynchronous): `value` = 0, `locked` = 0, `err` = 0, `wrap` = 0, `err_cnt` = 0, `wrap_cnt` = 0, state ACQ, `run` = 0, `have_prev` = 0, history registers 0.
- **Latency:** every output is registered and reflects the inputs sampled at the same rising edge.
  - `value`, `err` and `wrap` appear one cycle after `count` is presented.
  - `locked` rises on the edge that completes the LOCK_LEN-th match.
  - `locked` falls on the edge that detects the mismatch, together with `err`.
- `err` and `wrap` are single-cycle pulses; they can be asserted on consecutive cycles.
- If reset is asserted mid-operation, the state is lost immediately. After release, the first edge only loads history; comparison starts on the second edge.
- Upstream `cnt_reset` held high for several cycles: each cycle expects 000, and each sample of 000 is a match.

## Test plan
- Binary free-run, `mode` = 0, from 0 for 20 cycles:
  - `locked` rises after 4 matches;
  - `value` tracks the count;
  - `wrap` pulses once per 0→7→0 wrap, with `wrap_cnt` = 2 after two wraps;
  - `err_cnt` = 0.
- Gray free-run, `mode` = 1: `value` shows 0,1,2,…,7,0; `locked` = 1; no `err`.
- Fault injection while LOCKED in binary: drive 3→5 instead of 3→4.
  - `err` pulses for 1 cycle and `locked` falls.
  - `locked` rises again after 4 correct steps.
  - `err_cnt` = 1.
- Mode switch mid-stream: switch binary→Gray at count 011. The next count of 010 is accepted with no `err`, and the monitor stays locked.
- Upstream `cnt_reset` at count 110 (binary): next 000 accepted, `wrap` not asserted. `clear` asserted on the same edge as an error leaves `err_cnt` = 0.
- Saturation with `STAT_W` = 2: five injected errors, relocking between each, give `err_cnt` = 3. Asynchronous `reset` asserted mid-run drives all outputs to 0 immediately.
